// File: rtl/elevador_carro_pkg.sv
// elevador_pkg: car states, floor width and default timing shared by the elevator car files.
package elevador_pkg;
  localparam int LARG_ANDAR = 4;
  localparam int N_ANDARES_PAD = 16;
  localparam int T_VIAGEM_PAD = 100;
  localparam int T_PORTA_PAD = 200;
  typedef enum logic [1:0] {OCIOSO = 2'd0, SOBE = 2'd1, DESCE = 2'd2, PORTA = 2'd3} estado_t;
  function automatic estado_t destino(input logic [LARG_ANDAR-1:0] alvo, input logic [LARG_ANDAR-1:0] atual);
    return alvo > atual ? SOBE : alvo < atual ? DESCE : PORTA;
  endfunction
endpackage

// File: rtl/elevador_carro_if.sv
// elevador_carro_if: scheduler <-> car link; master is the scheduler, slave is the car.
interface elevador_carro_if;
  import elevador_pkg::*;
  logic [LARG_ANDAR-1:0] proxParada;
  logic [LARG_ANDAR-1:0] andarAtual;
  logic pedidoValido;
  logic segurarPorta;
  logic subindo;
  logic emMovimento;
  logic portaAberta;
  logic chegou;
  logic livre;
  logic [1:0] estado_db;
  modport master (
    output proxParada, pedidoValido, segurarPorta,
    input andarAtual, subindo, emMovimento, portaAberta, chegou, livre, estado_db
  );
  modport slave (
    input proxParada, pedidoValido, segurarPorta,
    output andarAtual, subindo, emMovimento, portaAberta, chegou, livre, estado_db
  );
endinterface

// File: rtl/elevador_carro_contador.sv
// contador_m: generic up-counter with synchronous zero, enable and terminal-count flag.
module contador_m #(
  parameter int LARG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zera,
  input  logic            en,
  input  logic [LARG-1:0] ultimo,
  output logic            fim
);
  logic [LARG-1:0] valor;
  always_ff @(posedge clk or posedge rst)
    if (rst) valor <= '0;
    else valor <= zera ? '0 : en ? valor + LARG'(1) : valor;
  assign fim = valor == ultimo;
endmodule

// File: rtl/elevador_carro.sv
// elevador_carro: car that steps one floor per travel interval toward the live target
// and holds the door open for a timed interval on arrival.
module elevador_carro
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = N_ANDARES_PAD,
  parameter int T_VIAGEM = T_VIAGEM_PAD,
  parameter int T_PORTA = T_PORTA_PAD
) (
  input logic clock,
  input logic reset,
  elevador_carro_if.slave bus
);
  localparam int TW = $clog2(T_VIAGEM > T_PORTA ? T_VIAGEM : T_PORTA);
  localparam logic [LARG_ANDAR-1:0] TOPO = LARG_ANDAR'(N_ANDARES - 1);
  localparam logic [LARG_ANDAR:0] LIMITE = N_ANDARES[LARG_ANDAR:0];
  estado_t estado, proxEstado;
  logic [LARG_ANDAR-1:0] andar, novoAndar;
  logic chegouR, passo, fim, zera, noLimite;
  contador_m #(.LARG(TW)) timer (
    .clk(clock),
    .rst(reset),
    .zera(zera),
    .en(1'b1),
    .ultimo(estado == PORTA ? TW'(T_PORTA - 1) : TW'(T_VIAGEM - 1)),
    .fim(fim)
  );
  // the post-step floor is judged against the live target, so a mid-trip change can reverse the car
  always_comb begin
    proxEstado = estado;
    passo = 1'b0;
    novoAndar = estado == DESCE ? andar - LARG_ANDAR'(1) : andar + LARG_ANDAR'(1);
    noLimite = estado == DESCE ? andar == '0 : andar == TOPO;
    zera = estado == OCIOSO || fim || (estado == PORTA && bus.segurarPorta);
    if (estado == OCIOSO) begin
      if (bus.pedidoValido && {1'b0, bus.proxParada} < LIMITE) proxEstado = destino(bus.proxParada, andar);
    end else if (estado == PORTA) begin
      if (fim && !bus.segurarPorta) proxEstado = OCIOSO;
    end else if (fim) begin
      passo = !noLimite;
      proxEstado = noLimite || !bus.pedidoValido ? OCIOSO : destino(bus.proxParada, novoAndar);
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado <= OCIOSO;
      andar <= '0;
      chegouR <= 1'b0;
    end else begin
      estado <= proxEstado;
      if (passo) andar <= novoAndar;
      chegouR <= proxEstado == PORTA && estado != PORTA;
    end
  assign bus.andarAtual = andar;
  assign bus.chegou = chegouR;
  assign bus.subindo = estado == SOBE;
  assign bus.emMovimento = estado == SOBE || estado == DESCE;
  assign bus.portaAberta = estado == PORTA;
  assign bus.livre = estado == OCIOSO;
  assign bus.estado_db = estado;
endmodule

// File: tb/tb_elevador_carro.sv
// tb_elevador_carro: directed trips with a queue of expected (cycle, floor, state, chegou) events
// checked by an independent monitor whenever the car's observable tuple changes.
module tb_elevador_carro;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon = 1'b0;
  int cyc = 0;
  int testes = 0;
  int falhas = 0;
  int base = 0;
  typedef struct {
    int ciclo;
    logic [3:0] andar;
    logic [1:0] estado;
    logic chegou;
  } ev_t;
  ev_t fila[$];
  ev_t e;
  logic [1:0] expEstado = 2'd0;
  logic [6:0] cur;
  logic [6:0] prev = 7'd0;
  elevador_carro_if bus();
  elevador_carro_if bus8();
  elevador_carro #(.N_ANDARES(16), .T_VIAGEM(4), .T_PORTA(6)) dut (.clock(clk), .reset(reset), .bus(bus));
  elevador_carro #(.N_ANDARES(8), .T_VIAGEM(4), .T_PORTA(6)) dut8 (.clock(clk), .reset(reset), .bus(bus8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nome, input int atual, input int esperado);
    testes++;
    if (atual != esperado) begin
      falhas++;
      $display("FAIL %s @%0d: got %0d, expected %0d", nome, cyc, atual, esperado);
    end
  endtask
  task automatic ev(input int dt, input int a, input int s, input int c);
    ev_t x;
    x.ciclo = base + dt;
    x.andar = 4'(a);
    x.estado = 2'(s);
    x.chegou = c[0];
    fila.push_back(x);
  endtask
  task automatic pedir(input int p);
    @(negedge clk);
    bus.proxParada = 4'(p);
    bus.pedidoValido = 1'b1;
    base = cyc + 1;
  endtask
  task automatic ate(input int dt);
    while (cyc < base + dt) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (mon) begin
      cur = {bus.andarAtual, bus.estado_db, bus.chegou};
      if (cur != prev) begin
        testes++;
        if (fila.size() == 0) begin
          falhas++;
          $display("FAIL unexpected_event @%0d: andar=%0d estado=%0d chegou=%0d", cyc, cur[6:3], cur[2:1], cur[0]);
        end else begin
          e = fila.pop_front();
          expEstado = e.estado;
          if (cyc != e.ciclo || cur != {e.andar, e.estado, e.chegou}) begin
            falhas++;
            $display("FAIL event @%0d: andar=%0d estado=%0d chegou=%0d, expected @%0d andar=%0d estado=%0d chegou=%0d",
                     cyc, cur[6:3], cur[2:1], cur[0], e.ciclo, e.andar, e.estado, e.chegou);
          end
        end
        prev = cur;
      end
      chk("flags_sub_mov_porta_livre", int'({bus.subindo, bus.emMovimento, bus.portaAberta, bus.livre}),
          int'({expEstado == 2'd1, expEstado == 2'd1 || expEstado == 2'd2, expEstado == 2'd3, expEstado == 2'd0}));
    end
  end
  initial begin
    bus.proxParada = 4'd0;
    bus.pedidoValido = 1'b0;
    bus.segurarPorta = 1'b0;
    bus8.proxParada = 4'd12;
    bus8.pedidoValido = 1'b1;
    bus8.segurarPorta = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_andar", int'(bus.andarAtual), 0);
    chk("reset_estado", int'(bus.estado_db), 0);
    chk("reset_livre", int'(bus.livre), 1);
    chk("reset_chegou", int'(bus.chegou), 0);
    chk("reset_subindo", int'(bus.subindo), 0);
    chk("reset_movimento", int'(bus.emMovimento), 0);
    chk("reset_porta", int'(bus.portaAberta), 0);
    reset = 1'b0;
    prev = 7'd0;
    mon = 1'b1;
    // 0 -> 3 upward trip
    pedir(3);
    ev(0, 0, 1, 0); ev(4, 1, 1, 0); ev(8, 2, 1, 0); ev(12, 3, 3, 1); ev(13, 3, 3, 0); ev(18, 3, 0, 0);
    ate(13); bus.pedidoValido = 1'b0; ate(20);
    // same-floor request with the door held for 10 cycles
    pedir(3);
    ev(0, 3, 3, 1); ev(1, 3, 3, 0); ev(16, 3, 0, 0);
    ate(0); bus.segurarPorta = 1'b1; bus.pedidoValido = 1'b0;
    ate(10); bus.segurarPorta = 1'b0; ate(18);
    // 3 -> 0 downward trip
    pedir(0);
    ev(0, 3, 2, 0); ev(4, 2, 2, 0); ev(8, 1, 2, 0); ev(12, 0, 3, 1); ev(13, 0, 3, 0); ev(18, 0, 0, 0);
    ate(13); bus.pedidoValido = 1'b0; ate(20);
    // 0 -> 5, target moved to 1 while at floor 2: reverses at 3
    pedir(5);
    ev(0, 0, 1, 0); ev(4, 1, 1, 0); ev(8, 2, 1, 0); ev(12, 3, 2, 0); ev(16, 2, 2, 0);
    ev(20, 1, 3, 1); ev(21, 1, 3, 0); ev(26, 1, 0, 0);
    ate(8); bus.proxParada = 4'd1; ate(21); bus.pedidoValido = 1'b0; ate(28);
    // 1 -> 15, request dropped at floor 4: stops at 5 without door
    pedir(15);
    ev(0, 1, 1, 0); ev(4, 2, 1, 0); ev(8, 3, 1, 0); ev(12, 4, 1, 0); ev(16, 5, 0, 0);
    ate(12); bus.pedidoValido = 1'b0; ate(20);
    // 5 -> 15 top floor, then 15 -> 0 without wrap
    pedir(15);
    ev(0, 5, 1, 0);
    for (int k = 1; k <= 9; k++) ev(4 * k, 5 + k, 1, 0);
    ev(40, 15, 3, 1); ev(41, 15, 3, 0); ev(46, 15, 0, 0);
    ate(41); bus.pedidoValido = 1'b0; ate(48);
    pedir(0);
    ev(0, 15, 2, 0);
    for (int k = 1; k <= 14; k++) ev(4 * k, 15 - k, 2, 0);
    ev(60, 0, 3, 1); ev(61, 0, 3, 0); ev(66, 0, 0, 0);
    ate(61); bus.pedidoValido = 1'b0; ate(68);
    // asynchronous reset between floors 6 and 7
    pedir(7);
    ev(0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) ev(4 * k, k, 1, 0);
    ate(26);
    #2;
    mon = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_andar", int'(bus.andarAtual), 0);
    chk("async_rst_estado", int'(bus.estado_db), 0);
    chk("async_rst_livre", int'(bus.livre), 1);
    chk("async_rst_movimento", int'(bus.emMovimento), 0);
    chk("async_rst_subindo", int'(bus.subindo), 0);
    bus.pedidoValido = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    prev = 7'd0;
    expEstado = 2'd0;
    mon = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_andar", int'(bus.andarAtual), 0);
    chk("post_rst_livre", int'(bus.livre), 1);
    // out-of-range target on an 8-floor car is ignored
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("n8_livre", int'(bus8.livre), 1);
      chk("n8_andar", int'(bus8.andarAtual), 0);
    end
    chk("fila_pendente", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end
endmodule
